// File: rtl/sa_audio_pkg.sv
// Shared definitions for the sound-generator serial audio path:
// receiver states, default word width and word-clock channel encoding.
package sa_audio_pkg;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_t;

  // Bits per channel word, shared with the gate-array transmitter model.
  localparam int DEFAULT_WORD_BITS = 16;

  // Word-clock level that marks the left channel.
  localparam logic LRCK_LEFT = 1'b0;

endpackage

// File: rtl/sa_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall strobes
// derived from one extra flop after the synchronized level.
module sa_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], din};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign level = chain_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/sa_audio_serial_rx.sv
// Oversampling receiver for the gate-array serial stereo stream: rebuilds
// left/right words and presents each stereo frame on a valid/ready port.
module sa_audio_serial_rx
  import sa_audio_pkg::*;
#(
  parameter int WORD_BITS   = DEFAULT_WORD_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ser_clk,
  input  logic                 ser_lrck,
  input  logic                 ser_data,
  output logic [WORD_BITS-1:0] out_left,
  output logic [WORD_BITS-1:0] out_right,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 err_clr,
  output logic                 short_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(WORD_BITS + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(WORD_BITS);

  logic bit_strobe, lrck_rise, lrck_fall, data_sync;
  logic clk_level_unused, clk_fall_unused, lrck_level_unused;
  logic data_rise_unused, data_fall_unused;

  sa_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(clk), .rst(rst), .din(ser_clk),
    .level(clk_level_unused), .rise(bit_strobe), .fall(clk_fall_unused)
  );

  sa_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
    .clk(clk), .rst(rst), .din(ser_lrck),
    .level(lrck_level_unused), .rise(lrck_rise), .fall(lrck_fall)
  );

  sa_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk(clk), .rst(rst), .din(ser_data),
    .level(data_sync), .rise(data_rise_unused), .fall(data_fall_unused)
  );

  logic left_start, right_start;
  assign left_start  = (LRCK_LEFT == 1'b0) ? lrck_fall : lrck_rise;
  assign right_start = (LRCK_LEFT == 1'b0) ? lrck_rise : lrck_fall;

  rx_state_t             state_q, state_d;
  logic [WORD_BITS-1:0]  shift_q, shift_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WORD_BITS-1:0]  left_hold_q, left_hold_d;
  logic [WORD_BITS-1:0]  justified;
  logic [CW-1:0]         pad_bits;
  logic                  new_word, word_close, frame_done;

  // A short word keeps its received bits in the MSBs; count 0 shifts out to 0.
  assign pad_bits  = FULL_COUNT - count_q;
  assign justified = shift_q << pad_bits;

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    left_hold_d = left_hold_q;
    new_word    = 1'b0;
    word_close  = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      ALIGN: begin
        if (left_start) begin
          state_d  = LEFT;
          new_word = 1'b1;
        end
      end
      LEFT: begin
        if (right_start) begin
          left_hold_d = justified;
          word_close  = 1'b1;
          new_word    = 1'b1;
          state_d     = RIGHT;
        end
      end
      RIGHT: begin
        if (left_start) begin
          word_close = 1'b1;
          frame_done = 1'b1;
          new_word   = 1'b1;
          state_d    = LEFT;
        end
      end
      default: state_d = ALIGN;
    endcase

    if (new_word) begin
      shift_d = '0;
      count_d = '0;
    end

    // Word-clock edge is handled above, so a coincident bit opens the new word.
    if (state_d != ALIGN && bit_strobe && count_d < FULL_COUNT) begin
      shift_d = {shift_d[WORD_BITS-2:0], data_sync};
      count_d = count_d + CW'(1);
    end
  end

  logic short_set, overrun_set, out_accept;
  assign short_set   = word_close && (count_q < FULL_COUNT);
  assign out_accept  = !out_valid || out_ready;
  assign overrun_set = frame_done && !out_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ALIGN;
      shift_q     <= '0;
      count_q     <= '0;
      left_hold_q <= '0;
      out_left    <= '0;
      out_right   <= '0;
      out_valid   <= 1'b0;
      short_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      left_hold_q <= left_hold_d;

      if (frame_done && out_accept) begin
        out_left  <= left_hold_q;
        out_right <= justified;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      short_err   <= short_set   | (short_err   & ~err_clr);
      overrun_err <= overrun_set | (overrun_err & ~err_clr);
    end
  end

endmodule
